event_encoder: RTL and testbench

Parametrised, registered successor to the 10-to-4 BCD encoder. Latches multi-hot event requests from `cin` into a pending set. Issues the binary index of one pending event at a time through a valid/ready output slot, and clears each event as it is issued. Sits between raw event/interrupt lines and a consumer that can take only one encoded index per cycle.

---
 rtl/event_encoder_pkg.sv | 8 +
 rtl/event_encoder_priority_pick.sv | 20 ++
 rtl/event_encoder.sv | 70 +++++++
 tb/tb_event_encoder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/event_encoder_pkg.sv
// event_encoder_pkg: shared constants, index-width helper and index type for event_encoder
package event_encoder_pkg;
  localparam int N_DEF = 10;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  typedef logic [idx_w(N_DEF)-1:0] idx_t;
endpackage

// File: rtl/event_encoder_priority_pick.sv
// priority_pick: lowest-index selector over req & mask; ports req/mask (N), idx (W), hit
module priority_pick #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx,
  output logic         hit
);
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i] && mask[i]) begin
        idx = W'(i);
        hit = 1'b1;
      end
  end
endmodule

// File: rtl/event_encoder.sv
// event_encoder: latches multi-hot events and issues one binary index per cycle over valid/ready
// Ports: clk, rst_n (async, active-low), en, cin[N], clr, ready -> cout[W], valid, pending[N], overflow
// EVENT_ENCODER_ROUND_ROBIN_EN selects round-robin arbitration; otherwise lowest index wins
module event_encoder
  import event_encoder_pkg::*;
#(
  parameter  int N = N_DEF,
  localparam int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] cin,
  input  logic         clr,
  input  logic         ready,
  output logic [W-1:0] cout,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic         overflow
);
  logic [N-1:0] pending_q, pending_d, load_mask;
  logic [W-1:0] cout_q, cout_d, sel_idx;
  logic         valid_q, valid_d, overflow_q, overflow_d, sel_hit, slot_free, load;
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d, hi_idx, lo_idx;
  logic [N-1:0] above;
  logic         hi_hit, lo_hit;
  always_comb begin
    above = '0;
    for (int i = 0; i < N; i++) above[i] = i > int'(ptr_q);
  end
  // Search strictly above the last issued index first, then wrap to the lowest pending bit.
  priority_pick #(.N(N), .W(W)) u_hi (.req(pending_q), .mask(above), .idx(hi_idx), .hit(hi_hit));
  priority_pick #(.N(N), .W(W)) u_lo (.req(pending_q), .mask({N{1'b1}}), .idx(lo_idx), .hit(lo_hit));
  assign sel_idx = hi_hit ? hi_idx : lo_idx;
  assign sel_hit = lo_hit;
  assign ptr_d   = (!clr && load) ? sel_idx : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= W'(N - 1);
    else ptr_q <= ptr_d;
`else
  priority_pick #(.N(N), .W(W)) u_pick (.req(pending_q), .mask({N{1'b1}}), .idx(sel_idx), .hit(sel_hit));
`endif
  always_comb begin
    slot_free  = !valid_q || ready;
    load       = slot_free && sel_hit;
    load_mask  = load ? (N'(1) << sel_idx) : '0;
    // A bit re-asserted on the edge it is loaded stays pending (set wins over clear).
    pending_d  = clr ? '0 : (pending_q & ~load_mask) | (en ? cin : '0);
    overflow_d = !clr && (overflow_q || (en && |(cin & pending_q & ~load_mask)));
    valid_d    = !clr && (slot_free ? sel_hit : valid_q);
    cout_d     = (!clr && load) ? sel_idx : cout_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending_q  <= '0;
      cout_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      cout_q     <= cout_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  assign cout     = cout_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_event_encoder.sv
// tb_event_encoder: randomized and directed checks of event_encoder against a set/slot reference model
module tb_event_encoder;
  localparam int N = 10;
  logic         clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0, ready = 1'b0;
  logic [N-1:0] cin = '0;
  logic [3:0]   cout;
  logic         valid, overflow;
  logic [N-1:0] pending;
  int checks = 0, errors = 0;
  bit m_pend[N];
  bit m_valid, m_ovf;
  int m_cout, m_ptr, prev;
  event_encoder #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cin(cin), .clr(clr), .ready(ready),
    .cout(cout), .valid(valid), .pending(pending), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v = 0;
    for (int i = 0; i < N; i++) if (m_pend[i]) v += 32'(1) << i;
    return v;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    m_valid = 0; m_ovf = 0; m_cout = 0; m_ptr = N - 1;
  endtask
  task automatic model_edge();
    bit free;
    bit nxt[N];
    int pick;
    if (clr) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_valid = 0; m_ovf = 0;
      return;
    end
    free = !m_valid || ready;
    pick = -1;
    if (free)
      for (int k = 1; k <= N && pick < 0; k++) begin
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
        int j = (m_ptr + k) % N;
`else
        int j = k - 1;
`endif
        if (m_pend[j]) pick = j;
      end
    nxt = m_pend;
    if (pick >= 0) nxt[pick] = 0;
    if (en)
      for (int i = 0; i < N; i++)
        if (cin[i]) begin
          if (m_pend[i] && i != pick) m_ovf = 1;
          nxt[i] = 1;
        end
    if (free) begin
      m_valid = pick >= 0;
      if (pick >= 0) begin m_cout = pick; m_ptr = pick; end
    end
    m_pend = nxt;
  endtask
  task automatic cyc(input logic e, input logic [N-1:0] c, input logic cl, input logic r);
    @(negedge clk);
    en = e; cin = c; clr = cl; ready = r;
    @(posedge clk);
    model_edge();
    #1;
    chk("cout", 32'(cout), 32'(m_cout));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("pending", 32'(pending), m_pend_vec());
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask
  initial begin
    model_reset();
    #1;
    chk("rst_cout", 32'(cout), 0);
    chk("rst_valid", 32'(valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 10'b1000100101, 0, 1);
    cyc(0, 0, 0, 1); chk("mh0", 32'(cout), 0);
    cyc(0, 0, 0, 1); chk("mh2", 32'(cout), 2);
    cyc(0, 0, 0, 1); chk("mh5", 32'(cout), 5);
    cyc(0, 0, 0, 1); chk("mh9", 32'(cout), 9); chk("mh9_valid", 32'(valid), 1);
    cyc(0, 0, 0, 1); chk("mh_drain", 32'(valid), 0);
    cyc(1, 10'b0000011000, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("bp_cout", 32'(cout), 3); chk("bp_pend", 32'(pending), 32'h010);
    cyc(0, 0, 0, 1); chk("bp_cout4", 32'(cout), 4); chk("bp_valid4", 32'(valid), 1);
    cyc(0, 0, 0, 1); chk("bp_drain", 32'(valid), 0);
    cyc(1, 10'b0000000010, 0, 0);
    cyc(0, 0, 0, 0); chk("ov_slot", 32'(cout), 1);
    cyc(1, 10'b0010000000, 0, 0);
    cyc(1, 10'b0010000000, 0, 0); chk("ov_set", 32'(overflow), 1);
    cyc(0, 0, 1, 0);
    chk("clr_pend", 32'(pending), 0); chk("clr_valid", 32'(valid), 0); chk("clr_ovf", 32'(overflow), 0);
    for (int i = 0; i < N; i++) begin
      cyc(1, N'(1) << i, 0, 1);
      if (i > 0) begin
        chk("sweep_cout", 32'(cout), 32'(i - 1));
        chk("sweep_valid", 32'(valid), 1);
      end
    end
    cyc(0, 0, 0, 1); chk("sweep_cout9", 32'(cout), 9);
    cyc(0, 0, 0, 1);
    cyc(0, '1, 0, 1);
    cyc(0, '1, 0, 1); chk("en0_valid", 32'(valid), 0); chk("en0_pend", 32'(pending), 0);
    cyc(1, 10'b0000000110, 0, 1);
    cyc(1, 10'b0000000110, 0, 1);
    prev = 32'(cout);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 10'b0000000110, 0, 1);
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
      chk("arb_alt", 32'(cout), 32'(3 - prev));
`else
      chk("arb_fixed", 32'(cout), 1);
`endif
      prev = 32'(cout);
    end
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 3) != 0), N'($urandom), 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 2) != 0));
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_cout", 32'(cout), 0); chk("async_valid", 32'(valid), 0);
    chk("async_pend", 32'(pending), 0); chk("async_ovf", 32'(overflow), 0);
    @(negedge clk);
    en = 1'b0; clr = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 50) == 0), 1'($urandom_range(0, 3) != 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
